// File: rtl/mod_mul_host_if.sv
// Operand/result streams plus the en/busy/done link to the multiplier core.
// slave = host side (mod_mul_host); master = sequencer, consumer and core side.
interface mod_mul_host_if #(parameter int W = 12);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_r;
  logic         mm_en;
  logic [W-1:0] mm_a;
  logic [W-1:0] mm_b;
  logic         mm_busy;
  logic         mm_done;
  logic [W-1:0] mm_r;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mm_busy, mm_done, mm_r,
    output in_ready, out_valid, out_r, mm_en, mm_a, mm_b
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, mm_busy, mm_done, mm_r,
    input  in_ready, out_valid, out_r, mm_en, mm_a, mm_b
  );
endinterface

// File: rtl/mod_mul_host.sv
// Issues operand pairs one at a time to the modular multiplier and returns results via a 2-entry FWFT FIFO.
// Latency: accept at N, mm_en at N+1, result visible the cycle after mm_done.
// Backpressure: in_ready drops while an op is in flight, the FIFO is full, the core is busy, or after a timeout.
module mod_mul_host #(
  parameter int W       = 12,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mod_mul_host_if.slave    bus,
  output logic             timeout,
  output logic [CNT_W-1:0] op_count
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wdog;
  logic [W-1:0]    mm_a_q, mm_b_q;
  logic [W-1:0]    fifo_head, fifo_tail;
  logic [1:0]      fifo_count;
  logic            accept, push, pop, wdog_hit, ready_c, en_c;

  // wdog becomes TIMEOUT-1 on the same edge that moves us to ERR
  assign wdog_hit = (wdog == WD_W'(TIMEOUT - 2));
  assign pop      = (fifo_count != 2'd0) && bus.out_ready;

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    en_c      = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        ready_c = (fifo_count < 2'd2) && !bus.mm_busy;
        if (bus.in_valid && ready_c) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        en_c      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.mm_done) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else if (wdog_hit) begin
          state_nxt = ERR;
        end
      end
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = ready_c;
  assign bus.mm_en     = en_c;
  assign bus.mm_a      = mm_a_q;
  assign bus.mm_b      = mm_b_q;
  assign bus.out_valid = (fifo_count != 2'd0);
  assign bus.out_r     = (fifo_count != 2'd0) ? fifo_head : '0;
  assign timeout       = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_a_q   <= '0;
      mm_b_q   <= '0;
      wdog     <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        mm_a_q <= bus.in_a;
        mm_b_q <= bus.in_b;
      end
      if (state == ISSUE)     wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 1'b1;
      if (push) op_count <= op_count + 1'b1;
    end
  end

  // A push always has a free slot: admission required count<2 and nothing else can push meanwhile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_head  <= '0;
      fifo_tail  <= '0;
      fifo_count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) fifo_head <= bus.mm_r;
          else                    fifo_tail <= bus.mm_r;
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          fifo_head  <= fifo_tail;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd2) begin
            fifo_head <= fifo_tail;
            fifo_tail <= bus.mm_r;
          end else begin
            fifo_head <= bus.mm_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_host.sv
// Scoreboard bench for mod_mul_host: a behavioural core model answers mm_en, results are checked in order.
module tb_mod_mul_host;
  localparam int W = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        timeout;
  logic [31:0] op_count;

  mod_mul_host_if #(.W(W)) ifc ();

  mod_mul_host #(.W(W), .TIMEOUT(64), .CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .timeout  (timeout),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int core_mode = 0;   // 0: answers after 1..5 cycles, 1: never answers
  bit core_clr = 1'b0;
  bit spur_req = 1'b0;
  int rdy_mode = 1;    // 0: stall, 1: always ready, 2: random
  int en_count = 0;
  bit pending = 1'b0;
  bit prev_en = 1'b0;
  int dly = 0;
  int ca = 0;
  int cb = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // behavioural multiplier core
  initial begin
    ifc.mm_busy = 1'b0;
    ifc.mm_done = 1'b0;
    ifc.mm_r    = '0;
    forever begin
      @(negedge clk);
      ifc.mm_done = 1'b0;
      if (core_clr) begin
        pending     = 1'b0;
        prev_en     = 1'b0;
        ifc.mm_busy = 1'b0;
      end else begin
        if (pending) begin
          chk("mm_a_stable", ifc.mm_a, ca);
          chk("mm_b_stable", ifc.mm_b, cb);
          if (core_mode == 0) begin
            if (dly == 0) begin
              ifc.mm_done = 1'b1;
              ifc.mm_r    = 12'((ca * cb) % 3329);
              ifc.mm_busy = 1'b0;
              pending     = 1'b0;
            end else begin
              dly--;
            end
          end
        end else if (spur_req) begin
          ifc.mm_done = 1'b1;
          ifc.mm_r    = 12'd5;
          spur_req    = 1'b0;
        end
        if (ifc.mm_en) begin
          chk("mm_en_single_cycle", prev_en, 0);
          en_count++;
          if (!pending) begin
            pending     = 1'b1;
            ca          = int'(ifc.mm_a);
            cb          = int'(ifc.mm_b);
            dly         = $urandom_range(0, 4);
            ifc.mm_busy = 1'b1;
          end
        end
        prev_en = ifc.mm_en;
      end
    end
  end

  // consumer
  initial begin
    ifc.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rdy_mode == 2) ifc.out_ready = 1'($urandom_range(0, 1));
      else               ifc.out_ready = (rdy_mode == 1);
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got r=%0d expected no result", ifc.out_r);
        end else begin
          chk("out_r", ifc.out_r, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "time limit");
  end

  task automatic send(input int a, input int b, input int exp, input bit expect_result);
    int n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_a     = 12'(a);
    ifc.in_b     = 12'(b);
    #1;
    while (!ifc.in_ready && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_accepted", ifc.in_ready, 1);
    if (ifc.in_ready && expect_result) exp_q.push_back(exp);
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int k;
    int en0;
    int a;
    int b;
    ifc.in_valid = 1'b0;
    ifc.in_a     = '0;
    ifc.in_b     = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_out_r", ifc.out_r, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_mm_en", ifc.mm_en, 0);
    chk("rst_mm_a", ifc.mm_a, 0);
    chk("rst_mm_b", ifc.mm_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_in_ready", ifc.in_ready, 1);
    @(negedge clk);

    // single op
    send(3328, 3328, 1, 1'b1);
    wait_drain();
    repeat (2) @(negedge clk);
    chk("t1_op_count", op_count, 1);
    chk("t1_en_pulses", en_count, 1);

    // operand extremes
    send(4095, 4095, 852, 1'b1);
    send(3000, 3000, 1713, 1'b1);
    wait_drain();
    chk("t2_op_count", op_count, 3);

    // backpressure: two results fill the FIFO, third pair stalls
    rdy_mode = 0;
    send(1, 1, 1, 1'b1);
    send(2, 2, 4, 1'b1);
    fork
      send(0, 0, 0, 1'b1);
      begin
        repeat (20) @(negedge clk);
        #1;
        chk("bp_in_ready_low", ifc.in_ready, 0);
        chk("bp_q_size", exp_q.size(), 2);
        chk("bp_out_valid", ifc.out_valid, 1);
        chk("bp_head", ifc.out_r, 1);
        rdy_mode = 1;
      end
    join
    wait_drain();
    repeat (2) @(negedge clk);
    chk("t3_op_count", op_count, 6);

    // spurious done while idle
    spur_req = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("spur_out_valid", ifc.out_valid, 0);
    chk("spur_op_count", op_count, 6);
    @(negedge clk);

    // watchdog timeout
    core_mode = 1;
    en0 = en_count;
    send(7, 7, 0, 1'b0);
    k = 0;
    while (!timeout && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("timeout_cycles", k, 64);
    chk("timeout_set", timeout, 1);
    ifc.in_valid = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("err_in_ready", ifc.in_ready, 0);
    chk("err_no_issue", en_count, en0 + 1);
    chk("err_sticky", timeout, 1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    core_clr = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    core_clr = 1'b0;
    #1;
    chk("post_rst_timeout", timeout, 0);
    chk("post_rst_in_ready", ifc.in_ready, 1);
    @(negedge clk);

    // reset in the middle of WAIT, then a late done
    send(9, 9, 0, 1'b0);
    repeat (5) @(negedge clk);
    core_clr = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_mm_a", ifc.mm_a, 0);
    chk("midrst_mm_b", ifc.mm_b, 0);
    chk("midrst_mm_en", ifc.mm_en, 0);
    chk("midrst_out_valid", ifc.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    core_clr = 1'b0;
    core_mode = 0;
    spur_req = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("late_done_op_count", op_count, 0);
    chk("late_done_out_valid", ifc.out_valid, 0);
    @(negedge clk);

    // random stress
    rdy_mode = 2;
    en0 = en_count;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 4095);
      b = $urandom_range(0, 4095);
      send(a, b, (a * b) % 3329, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();
    repeat (3) @(negedge clk);
    chk("stress_op_count", op_count, 1000);
    chk("stress_en_pulses", en_count - en0, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
